// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle RV32I datapath: steps each instruction through
// fetch/decode/execute/writeback and drives ALU code, datapath selects and strobes.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | IR <= mem[PC], PC <= PC+4
// DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= ReadData
// MEMWRITE | mem[ALUOut] <= rs2
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut if taken
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// JALR     | ALUOut <= rs1+imm
// LUI      | ALUOut <= 0+imm
// TRAP     | illegal instruction, parked until reset
module multicycle_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [2:0] imm_src,
   output logic [3:0] alu_control,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1111;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b0011;

   state_t state_q, state_d;

   logic pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
   logic br_legal, br_taken;

   // Immediate forms carry no funct7, so bit 30 only selects SUB for R-type.
   function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                          input logic is_imm);
      case (f3)
         3'b000:  alu_dec = (f7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_dec = ALU_SLL;
         3'b010:  alu_dec = ALU_SLT;
         3'b011:  alu_dec = ALU_SLTU;
         3'b100:  alu_dec = ALU_XOR;
         3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_dec = ALU_OR;
         default: alu_dec = ALU_AND;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign br_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
   // funct3[0] inverts the sense; BEQ/BGE/BGEU fire on zero, the rest on !zero.
   assign br_taken = br_legal && (funct3[0] ^ (funct3[2] ? !zero : zero));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_ALUWB;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = br_legal ? S_FETCH : S_TRAP;
         S_JAL:      state_d = S_ALUWB;
         S_JALR:     state_d = S_JAL;
         S_LUI:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
   end

   always_comb begin
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      result_src    = 2'b00;
      alu_control   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            alu_src_b    = 2'b10;
            result_src   = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR, S_EXECI, S_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            if (state_q == S_EXECI) alu_control = alu_dec(funct3, funct7b5, 1'b1);
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_dec(funct3, funct7b5, 1'b0);
         end
         S_ALUWB: reg_write_raw = 1'b1;
         S_BRANCH: begin
            alu_src_a    = 2'b10;
            pc_write_raw = br_taken;
            case (funct3)
               3'b000, 3'b001: alu_control = ALU_SUB;
               3'b100, 3'b101: alu_control = ALU_SLT;
               3'b110, 3'b111: alu_control = ALU_SLTU;
               default:        alu_control = ALU_ADD;
            endcase
         end
         S_JAL: begin
            alu_src_a    = 2'b01;
            alu_src_b    = 2'b10;
            pc_write_raw = 1'b1;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_STORE:         imm_src = 3'b001;
         OP_BRANCH:        imm_src = 3'b010;
         OP_JAL:           imm_src = 3'b011;
         OP_LUI, OP_AUIPC: imm_src = 3'b100;
         default:          imm_src = 3'b000;
      endcase
   end

   // The state register clears asynchronously, but FETCH would still pulse its
   // strobes while reset is held, so every strobe is gated directly.
   assign pc_write  = pc_write_raw  & ~reset;
   assign ir_write  = ir_write_raw  & ~reset;
   assign mem_write = mem_write_raw & ~reset;
   assign reg_write = reg_write_raw & ~reset;
   assign illegal   = (state_q == S_TRAP);
   assign state     = state_q;

endmodule
